// File: rtl/dma_cmd_nword_fifo_pkg.sv
// Shared definitions for the single-clock multi-word DMA command FIFO:
// FSM encodings, command-size legality and index width helpers.
package dma_cmd_nword_fifo_pkg;

  localparam int CMD_WORDS_MIN = 1;
  localparam int CMD_WORDS_MAX = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_WRITE = 2'b10
  } fifo_state_e;

  function automatic bit cmd_words_legal(input int p);
    return (p >= CMD_WORDS_MIN) && (p <= CMD_WORDS_MAX);
  endfunction

  // A one-word command still needs a 1-bit index so the ports stay non-empty.
  function automatic int cmd_idx_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/dma_cmd_sdp_ram.sv
// Single-clock simple dual-port RAM with a registered read port.
// Read-during-write to the same address returns the previous contents.
module dma_cmd_sdp_ram #(
  parameter int P_DATA_WIDTH = 56,
  parameter int P_ADDR_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [P_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [P_DATA_WIDTH-1:0] wr_data_i,
  input  logic [P_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [P_DATA_WIDTH-1:0] rd_data_o
);

  logic [P_DATA_WIDTH-1:0] mem_q [2**P_ADDR_WIDTH];
  logic [P_DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dma_cmd_nword_fifo.sv
// DMA command FIFO: accepts a P_CMD_WORDS-word command per handshake, serialises
// it into word storage, and exposes it to the reader only once fully written.
//
//   state   | meaning
//   S_IDLE  | ready for a new command when enough space is free
//   S_WRITE | storing captured word[idx] at rear, one word per cycle
module dma_cmd_nword_fifo
  import dma_cmd_nword_fifo_pkg::*;
#(
  parameter int P_FIFO_DATA_WIDTH  = 56,
  parameter int P_FIFO_DEPTH_WIDTH = 9,
  parameter int P_CMD_WORDS        = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic                                      dma_cmd_wr_en,
  input  logic [P_CMD_WORDS*P_FIFO_DATA_WIDTH-1:0]  dma_cmd_wr_data,
  output logic                                      dma_cmd_wr_rdy_n,
  input  logic                                      rd_en,
  output logic [P_FIFO_DATA_WIDTH-1:0]              rd_data,
  output logic                                      rd_cmd_last,
  output logic                                      empty_n,
  output logic [P_FIFO_DEPTH_WIDTH:0]               cmd_count
);

  localparam int W     = P_FIFO_DATA_WIDTH;
  localparam int DW    = P_FIFO_DEPTH_WIDTH;
  localparam int PTR_W = DW + 1;
  localparam int IDX_W = cmd_idx_width(P_CMD_WORDS);

  localparam logic [PTR_W:0]   DEPTH_WORDS = (PTR_W+1)'(2**DW);
  localparam logic [PTR_W:0]   CMD_WORDS_L = (PTR_W+1)'(P_CMD_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(P_CMD_WORDS - 1);

  if (!cmd_words_legal(P_CMD_WORDS) || (P_CMD_WORDS > 2**DW)) begin : g_bad_cmd_words
    $error("dma_cmd_nword_fifo: P_CMD_WORDS out of range");
  end

  fifo_state_e                         state_q;
  logic [PTR_W-1:0]                    rear_q, commit_q, front_q, front_d;
  logic [IDX_W-1:0]                    idx_q, rd_idx_q, rd_idx_d;
  logic                                commit_pend_q;
  logic [DW:0]                         cmd_count_q, cmd_count_d;
  logic [P_CMD_WORDS*W-1:0]            cmd_buf_q;

  logic [PTR_W-1:0] used_words;
  logic [PTR_W:0]   free_words;
  logic             clear;
  logic             wr_accept;
  logic             pop;
  logic             last_pop;
  logic             ram_we;
  logic [W-1:0]     ram_wdata;

  assign clear      = rst | flush;
  assign used_words = rear_q - front_q;
  assign free_words = DEPTH_WORDS - {1'b0, used_words};

  assign dma_cmd_wr_rdy_n = rst | (state_q != S_IDLE) | (free_words < CMD_WORDS_L);
  assign wr_accept        = dma_cmd_wr_en & ~dma_cmd_wr_rdy_n;

  assign empty_n     = (front_q != commit_q);
  assign rd_cmd_last = empty_n & (rd_idx_q == LAST_IDX);
  assign pop         = rd_en & empty_n;
  assign last_pop    = pop & rd_cmd_last;
  assign cmd_count   = cmd_count_q;

  always_comb begin
    front_d  = front_q;
    rd_idx_d = rd_idx_q;
    if (pop) begin
      front_d  = front_q + 1'b1;
      rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
    end
  end

  always_comb begin
    cmd_count_d = cmd_count_q;
    unique case ({commit_pend_q, last_pop})
      2'b10:   cmd_count_d = cmd_count_q + 1'b1;
      2'b01:   cmd_count_d = cmd_count_q - 1'b1;
      default: cmd_count_d = cmd_count_q;
    endcase
  end

  // Clear wins over everything, including a command half-way through S_WRITE.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= S_IDLE;
      rear_q        <= '0;
      commit_q      <= '0;
      front_q       <= '0;
      idx_q         <= '0;
      rd_idx_q      <= '0;
      commit_pend_q <= 1'b0;
      cmd_count_q   <= '0;
    end else begin
      front_q       <= front_d;
      rd_idx_q      <= rd_idx_d;
      cmd_count_q   <= cmd_count_d;
      commit_pend_q <= 1'b0;
      if (commit_pend_q) begin
        commit_q <= rear_q;
      end
      unique case (state_q)
        S_IDLE: begin
          if (wr_accept) begin
            cmd_buf_q <= dma_cmd_wr_data;
            idx_q     <= '0;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          rear_q <= rear_q + 1'b1;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q       <= S_IDLE;
            commit_pend_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_we    = (state_q == S_WRITE) & ~clear;
  assign ram_wdata = cmd_buf_q[int'(idx_q)*W +: W];

  // Lookahead read address keeps the next head word on rd_data right after a pop.
  dma_cmd_sdp_ram #(
    .P_DATA_WIDTH (W),
    .P_ADDR_WIDTH (DW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (rear_q[DW-1:0]),
    .wr_data_i (ram_wdata),
    .rd_addr_i (front_d[DW-1:0]),
    .rd_data_o (rd_data)
  );

endmodule
